// File: rtl/seq_divider_16_bit.sv
// 16-bit unsigned restoring divider, one quotient bit per clock behind a
// start/busy/done handshake; trial subtractions run on a cla_16_bit adder.

module cla_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        // Block carries are fully looked ahead; only the carries inside a block ripple.
        c[0]  = c_in;
        c[4]  = gg[0] | (gp[0] & c_in);
        c[8]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        c[12] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
        c[16] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        sum   = p ^ c[15:0];
        c_out = c[16];
    end
endmodule

module seq_divider_16_bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [16:0] r_q, r_d;
    logic [15:0] q_q, q_d;
    logic [15:0] d_q, d_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic [16:0] r_shift;
    logic [15:0] q_shift;
    logic [15:0] trial;
    logic        no_borrow;
    logic        ok;

    assign r_shift = {r_q[15:0], q_q[15]};
    assign q_shift = {q_q[14:0], 1'b0};

    cla_16_bit u_cla (
        .a     (r_shift[15:0]),
        .b     (~d_q),
        .c_in  (1'b1),
        .sum   (trial),
        .c_out (no_borrow)
    );

    // A set bit 16 means the shifted remainder already exceeds any 16-bit divisor.
    assign ok = r_shift[16] | no_borrow;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d = divisor;
                    if (divisor == 16'h0000) begin
                        state_d     = DONE;
                        quotient_d  = 16'hFFFF;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = '0;
                        q_d     = dividend;
                        count_d = '0;
                    end
                end
            end
            RUN: begin
                r_d     = ok ? {1'b0, trial} : r_shift;
                q_d     = {q_shift[15:1], ok};
                count_d = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    state_d     = DONE;
                    quotient_d  = {q_shift[15:1], ok};
                    remainder_d = ok ? trial : r_shift[15:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16_bit.sv
// Bench for seq_divider_16_bit: directed cases with literal results, then
// random operands, all compared every cycle against a cycle-count/arithmetic model.

module tb_seq_divider_16_bit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    // {div_by_zero, dividend, divisor, quotient, remainder}
    logic [64:0] exp_q[$];

    // Model: busy cycles left for the current operation plus the results
    // the outputs must hold.
    int          m_left = 0;
    logic [15:0] m_a, m_b;
    logic [15:0] m_q = '0;
    logic [15:0] m_r = '0;
    logic        m_dbz = 1'b0;

    seq_divider_16_bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_q    = '0;
            m_r    = '0;
            m_dbz  = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                m_a = dividend;
                m_b = divisor;
                if (divisor == 16'h0000) begin
                    m_left = 1;
                    m_q    = 16'hFFFF;
                    m_r    = dividend;
                    m_dbz  = 1'b1;
                end else begin
                    m_left = 17;
                end
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_q   = m_a / m_b;
                m_r   = m_a % m_b;
                m_dbz = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        logic [31:0] recon;
        chk("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
        chk("done", {31'h0, done}, {31'h0, (m_left == 1)});
        chk("quotient", {16'h0, quotient}, {16'h0, m_q});
        chk("remainder", {16'h0, remainder}, {16'h0, m_r});
        chk("div_by_zero", {31'h0, div_by_zero}, {31'h0, m_dbz});
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: actual=1 expected=0 at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("result_q", {16'h0, quotient}, {16'h0, e[31:16]});
                chk("result_r", {16'h0, remainder}, {16'h0, e[15:0]});
                chk("result_dbz", {31'h0, div_by_zero}, {31'h0, e[64]});
                if (!e[64]) begin
                    recon = {16'h0, quotient} * {16'h0, e[47:32]} + {16'h0, remainder};
                    chk("invariant_sum", recon, {16'h0, e[63:48]});
                    chk("invariant_lt", {31'h0, (remainder < e[47:32])}, 32'h1);
                end
            end
        end
    end

    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: actual=no_done expected=done at t=%0t", $time);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input int exp_lat);
        int lat;
        bit seen;
        int guard = 0;
        while (m_left != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back({(b == 16'h0000), a, b, eq, er});
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        wait_done(lat, seen);
        chk("model_q", {16'h0, m_q}, {16'h0, eq});
        chk("model_r", {16'h0, m_r}, {16'h0, er});
        if (exp_lat > 0) chk("busy_cycles", lat, exp_lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lat;
        bit seen;
        logic [15:0] a, b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_quotient", {16'h0, quotient}, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_div(16'd100, 16'd7, 16'd14, 16'd2, 17);
        run_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 17);
        run_div(16'hFFFF, 16'h8000, 16'd1, 16'h7FFF, 17);
        run_div(16'd3, 16'd10, 16'd0, 16'd3, 17);
        run_div(16'd0, 16'd5, 16'd0, 16'd0, 17);
        run_div(16'd5, 16'd0, 16'hFFFF, 16'd5, 1);

        // A start pulsed mid-run must be ignored.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd3;
        start    = 1'b1;
        exp_q.push_back({1'b0, 16'd1000, 16'd3, 16'd333, 16'd1});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, seen);
        chk("ignored_start_q", {16'h0, quotient}, 32'd333);
        chk("ignored_start_r", {16'h0, remainder}, 32'd1);
        run_div(16'd9, 16'd2, 16'd4, 16'd1, 17);

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_quotient", {16'h0, quotient}, 32'h0);
        chk("abort_remainder", {16'h0, remainder}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_div(16'd50, 16'd6, 16'd8, 16'd2, 17);

        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 9))
                0:       b = 16'h0000;
                1, 2, 3: b = 16'($urandom_range(1, 15));
                4:       b = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h8000;
                default: b = 16'($urandom);
            endcase
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            if (b == 16'h0000) run_div(a, b, 16'hFFFF, a, 1);
            else               run_div(a, b, a / b, a % b, 17);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
